hdlc_tx_channel: RTL and testbench

Transmit-side serializer for the HDLC controller and the counterpart of the receive channel. It takes a frame of bytes from the TX buffer and emits one bit per `Clk` on `Tx`. The bit stream is an opening flag, zero-stuffed data, an optional zero-stuffed CRC-16, then a closing flag. An abort sequence replaces the frame tail when transmission is aborted. It sits between the TX buffer/register interface and the `Tx` pin.

---
 rtl/hdlc_tx_channel.sv | 218 +++++++++++++++++++++
 tb/tb_hdlc_tx_channel.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/hdlc_tx_channel.sv
// HDLC transmit serializer: opening flag, zero-stuffed data and optional CRC-16/X-25,
// closing flag, with an abort sequence that replaces the frame tail.
module hdlc_tx_channel #(
    parameter int MAX_FRAME = 126
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Tx_Enable,
    input  logic       Tx_ValidFrame,
    input  logic [6:0] Tx_FrameSize,
    input  logic       Tx_FCSen,
    input  logic       Tx_AbortFrame,
    input  logic [7:0] Tx_Data,
    output logic       Tx,
    output logic       Tx_RdBuff,
    output logic       Tx_Busy,
    output logic       Tx_Done,
    output logic       Tx_AbortedTrans,
    output logic [2:0] Tx_State
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SFLAG = 3'd1,
        DATA  = 3'd2,
        FCS   = 3'd3,
        EFLAG = 3'd4,
        ABORT = 3'd5
    } state_t;

    localparam logic [7:0] FLAG     = 8'h7E;
    localparam logic [6:0] MAX_SIZE = 7'(MAX_FRAME);

    state_t      state;
    logic [3:0]  bit_cnt;
    logic [15:0] shift_q;
    logic [7:0]  hold_q;
    logic [6:0]  bytes_left;
    logic        fcs_en;
    logic [2:0]  ones_cnt;
    logic [15:0] crc_q;
    logic        rd_dly;

    logic [6:0]  size_clamped;
    logic        abort_req;
    logic        stuff_now;
    logic [15:0] fcs_word;

    assign Tx_State = state;

    always_comb begin
        size_clamped = (Tx_FrameSize > MAX_SIZE) ? MAX_SIZE : Tx_FrameSize;
        abort_req    = Tx_AbortFrame || !Tx_Enable;
        stuff_now    = (ones_cnt == 3'd5);
        fcs_word     = ~crc_q;
    end

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[0] ^ b;
        crc_step = {1'b0, c[15:1]} ^ (fb ? 16'h8408 : 16'h0000);
    endfunction

    function automatic logic [2:0] count_one(input logic [2:0] c, input logic b);
        count_one = b ? c + 3'd1 : 3'd0;
    endfunction

    // Byte fetch: Tx_RdBuff is a one-cycle strobe; the buffer presents Tx_Data in the
    // following cycle and it is captured into hold_q at the end of that cycle.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state           <= IDLE;
            Tx              <= 1'b1;
            Tx_RdBuff       <= 1'b0;
            Tx_Busy         <= 1'b0;
            Tx_Done         <= 1'b0;
            Tx_AbortedTrans <= 1'b0;
            bit_cnt         <= 4'd0;
            shift_q         <= 16'h0000;
            hold_q          <= 8'h00;
            bytes_left      <= 7'd0;
            fcs_en          <= 1'b0;
            ones_cnt        <= 3'd0;
            crc_q           <= 16'hFFFF;
            rd_dly          <= 1'b0;
        end else begin
            Tx_RdBuff       <= 1'b0;
            Tx_Done         <= 1'b0;
            Tx_AbortedTrans <= 1'b0;
            rd_dly          <= Tx_RdBuff;
            if (rd_dly) hold_q <= Tx_Data;

            case (state)
                IDLE: begin
                    Tx <= 1'b1;
                    if (Tx_ValidFrame && Tx_Enable && (Tx_FrameSize != 7'd0)) begin
                        state      <= SFLAG;
                        Tx         <= FLAG[0];
                        bit_cnt    <= 4'd0;
                        Tx_Busy    <= 1'b1;
                        Tx_RdBuff  <= 1'b1;
                        bytes_left <= size_clamped;
                        fcs_en     <= Tx_FCSen;
                        crc_q      <= 16'hFFFF;
                    end
                end

                SFLAG: begin
                    if (abort_req) begin
                        state   <= ABORT;
                        Tx      <= 1'b1;
                        bit_cnt <= 4'd0;
                    end else if (bit_cnt == 4'd7) begin
                        state      <= DATA;
                        shift_q    <= {8'h00, hold_q};
                        Tx         <= hold_q[0];
                        crc_q      <= crc_step(crc_q, hold_q[0]);
                        ones_cnt   <= count_one(3'd0, hold_q[0]);
                        bit_cnt    <= 4'd0;
                        bytes_left <= bytes_left - 7'd1;
                        Tx_RdBuff  <= (bytes_left > 7'd1);
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                        Tx      <= FLAG[bit_cnt[2:0] + 3'd1];
                    end
                end

                DATA: begin
                    if (abort_req) begin
                        state   <= ABORT;
                        Tx      <= 1'b1;
                        bit_cnt <= 4'd0;
                    end else if (stuff_now) begin
                        // Inserted zero: the shift position and CRC hold still.
                        Tx       <= 1'b0;
                        ones_cnt <= 3'd0;
                    end else if (bit_cnt != 4'd7) begin
                        bit_cnt  <= bit_cnt + 4'd1;
                        shift_q  <= {1'b0, shift_q[15:1]};
                        Tx       <= shift_q[1];
                        crc_q    <= crc_step(crc_q, shift_q[1]);
                        ones_cnt <= count_one(ones_cnt, shift_q[1]);
                    end else if (bytes_left != 7'd0) begin
                        shift_q    <= {8'h00, hold_q};
                        Tx         <= hold_q[0];
                        crc_q      <= crc_step(crc_q, hold_q[0]);
                        ones_cnt   <= count_one(ones_cnt, hold_q[0]);
                        bit_cnt    <= 4'd0;
                        bytes_left <= bytes_left - 7'd1;
                        Tx_RdBuff  <= (bytes_left > 7'd1);
                    end else if (fcs_en) begin
                        state    <= FCS;
                        shift_q  <= fcs_word;
                        Tx       <= fcs_word[0];
                        ones_cnt <= count_one(ones_cnt, fcs_word[0]);
                        bit_cnt  <= 4'd0;
                    end else begin
                        state   <= EFLAG;
                        Tx      <= FLAG[0];
                        bit_cnt <= 4'd0;
                    end
                end

                FCS: begin
                    if (abort_req) begin
                        state   <= ABORT;
                        Tx      <= 1'b1;
                        bit_cnt <= 4'd0;
                    end else if (stuff_now) begin
                        Tx       <= 1'b0;
                        ones_cnt <= 3'd0;
                    end else if (bit_cnt != 4'd15) begin
                        bit_cnt  <= bit_cnt + 4'd1;
                        shift_q  <= {1'b0, shift_q[15:1]};
                        Tx       <= shift_q[1];
                        ones_cnt <= count_one(ones_cnt, shift_q[1]);
                    end else begin
                        state   <= EFLAG;
                        Tx      <= FLAG[0];
                        bit_cnt <= 4'd0;
                    end
                end

                EFLAG: begin
                    if (bit_cnt == 4'd7) begin
                        state   <= IDLE;
                        Tx      <= 1'b1;
                        Tx_Busy <= 1'b0;
                        Tx_Done <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                        Tx      <= FLAG[bit_cnt[2:0] + 3'd1];
                    end
                end

                ABORT: begin
                    // Seven ones then a zero (0x7F LSB first).
                    if (bit_cnt == 4'd7) begin
                        state           <= IDLE;
                        Tx              <= 1'b1;
                        Tx_Busy         <= 1'b0;
                        Tx_AbortedTrans <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                        Tx      <= (bit_cnt != 4'd6);
                    end
                end

                default: begin
                    state   <= IDLE;
                    Tx      <= 1'b1;
                    Tx_Busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hdlc_tx_channel.sv
// Directed bench for hdlc_tx_channel: per-cycle output logs after each frame request,
// compared against hand-built bit streams and event counts.
module tb_hdlc_tx_channel;

    localparam int LOG = 1100;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       Tx_Enable;
    logic       Tx_ValidFrame;
    logic [6:0] Tx_FrameSize;
    logic       Tx_FCSen;
    logic       Tx_AbortFrame;
    logic [7:0] Tx_Data;
    logic       Tx;
    logic       Tx_RdBuff;
    logic       Tx_Busy;
    logic       Tx_Done;
    logic       Tx_AbortedTrans;
    logic [2:0] Tx_State;

    int tests = 0;
    int fails = 0;

    logic [7:0] mem [0:127];
    int         rd_idx;
    logic       tx_log   [0:LOG-1];
    logic       rd_log   [0:LOG-1];
    logic       busy_log [0:LOG-1];
    logic       done_log [0:LOG-1];
    logic       ab_log   [0:LOG-1];
    logic       exp_q[$];

    always #5 Clk = ~Clk;

    hdlc_tx_channel #(.MAX_FRAME(126)) dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .Tx_Enable      (Tx_Enable),
        .Tx_ValidFrame  (Tx_ValidFrame),
        .Tx_FrameSize   (Tx_FrameSize),
        .Tx_FCSen       (Tx_FCSen),
        .Tx_AbortFrame  (Tx_AbortFrame),
        .Tx_Data        (Tx_Data),
        .Tx             (Tx),
        .Tx_RdBuff      (Tx_RdBuff),
        .Tx_Busy        (Tx_Busy),
        .Tx_Done        (Tx_Done),
        .Tx_AbortedTrans(Tx_AbortedTrans),
        .Tx_State       (Tx_State)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int j = 0; j < 8; j++) exp_q.push_back(b[j]);
    endtask

    task automatic push_bits(input logic [15:0] bits, input int n);
        for (int j = 0; j < n; j++) exp_q.push_back(bits[j]);
    endtask

    task automatic check_bits(input string tag, input int start);
        for (int k = 0; k < exp_q.size(); k++)
            check($sformatf("%s bit%0d", tag, k), 32'(tx_log[start+k]), 32'(exp_q[k]));
        exp_q.delete();
    endtask

    // which: 0 rd, 1 done, 2 aborted, 3 busy, 4 tx high
    function automatic int count(input int which, input int lo, input int hi);
        int n;
        n = 0;
        for (int c = lo; c <= hi; c++) begin
            case (which)
                0: n += int'(rd_log[c]);
                1: n += int'(done_log[c]);
                2: n += int'(ab_log[c]);
                3: n += int'(busy_log[c]);
                default: n += int'(tx_log[c]);
            endcase
        end
        return n;
    endfunction

    // Cycle 0 carries the Tx_ValidFrame request; log index i holds outputs seen in cycle i.
    task automatic frame(input int size, input int fcs, input int ncyc, input int vf_at,
                         input int ab_at, input int en_at, input int rst_at);
        rd_idx = 0;
        for (int c = 0; c < LOG; c++) begin
            tx_log[c] = 1'b0; rd_log[c] = 1'b0; busy_log[c] = 1'b0;
            done_log[c] = 1'b0; ab_log[c] = 1'b0;
        end
        for (int i = 0; i < ncyc; i++) begin
            Tx_ValidFrame = (i == 0) || (i == vf_at);
            Tx_FrameSize  = (i == vf_at) ? 7'd3 : 7'(size);
            Tx_FCSen      = 1'(fcs);
            Tx_AbortFrame = (i == ab_at);
            Tx_Enable     = !(en_at >= 0 && i >= en_at);
            Rst           = (i == rst_at);
            @(posedge Clk);
            #1;
            tx_log[i+1]   = Tx;
            rd_log[i+1]   = Tx_RdBuff;
            busy_log[i+1] = Tx_Busy;
            done_log[i+1] = Tx_Done;
            ab_log[i+1]   = Tx_AbortedTrans;
            if (Tx_RdBuff && rd_idx < 128) begin
                Tx_Data = mem[rd_idx];
                rd_idx++;
            end
        end
        Tx_ValidFrame = 1'b0;
        Tx_AbortFrame = 1'b0;
        Rst           = 1'b0;
    endtask

    initial begin
        Rst = 1'b1; Tx_Enable = 1'b1; Tx_ValidFrame = 1'b0; Tx_FrameSize = 7'd0;
        Tx_FCSen = 1'b0; Tx_AbortFrame = 1'b0; Tx_Data = 8'h00;
        for (int a = 0; a < 128; a++) mem[a] = 8'h00;
        repeat (3) @(posedge Clk);
        #1;
        check("reset tx", 32'(Tx), 32'd1);
        check("reset rdbuff", 32'(Tx_RdBuff), 32'd0);
        check("reset busy", 32'(Tx_Busy), 32'd0);
        check("reset done", 32'(Tx_Done), 32'd0);
        check("reset aborted", 32'(Tx_AbortedTrans), 32'd0);
        Rst = 1'b0;

        // Size 0 request is ignored
        frame(0, 0, 12, -1, -1, -1, -1);
        check("size0 busy", 32'(count(3, 1, 12)), 32'd0);
        check("size0 rdbuff", 32'(count(0, 1, 12)), 32'd0);
        check("size0 tx idle", 32'(count(4, 1, 12)), 32'd12);

        // CRC/framing on "123456789" with a second request mid-frame
        for (int a = 0; a < 9; a++) mem[a] = 8'h31 + 8'(a);
        frame(9, 1, 110, 30, -1, -1, -1);
        push_byte(8'h7E);
        for (int a = 0; a < 9; a++) push_byte(8'h31 + 8'(a));
        push_byte(8'h6E); push_byte(8'h90); push_byte(8'h7E);
        check_bits("crc", 1);
        check("crc busy c1", 32'(busy_log[1]), 32'd1);
        check("crc rd c1", 32'(rd_log[1]), 32'd1);
        check("crc busy span", 32'(count(3, 1, 104)), 32'd104);
        check("crc done c104", 32'(done_log[104]), 32'd0);
        check("crc done c105", 32'(done_log[105]), 32'd1);
        check("crc busy c105", 32'(busy_log[105]), 32'd0);
        check("crc tx c105", 32'(tx_log[105]), 32'd1);
        check("crc done count", 32'(count(1, 1, 110)), 32'd1);
        check("crc rd count", 32'(count(0, 1, 110)), 32'd9);
        check("crc ab count", 32'(count(2, 1, 110)), 32'd0);

        // Zero insertion on 0xFF; abort during closing flag is ignored
        mem[0] = 8'hFF;
        frame(1, 0, 30, -1, 20, -1, -1);
        push_byte(8'h7E); push_bits(16'h01DF, 9); push_byte(8'h7E);
        check_bits("stuff", 1);
        check("stuff busy c25", 32'(busy_log[25]), 32'd1);
        check("stuff done c26", 32'(done_log[26]), 32'd1);
        check("stuff busy c26", 32'(busy_log[26]), 32'd0);
        check("stuff tx c26", 32'(tx_log[26]), 32'd1);
        check("stuff ab count", 32'(count(2, 1, 30)), 32'd0);
        check("stuff rd count", 32'(count(0, 1, 30)), 32'd1);

        // Abort on the 3rd data bit
        for (int a = 0; a < 4; a++) mem[a] = 8'h55;
        frame(4, 0, 30, -1, 11, -1, -1);
        push_byte(8'h7E); push_bits(16'h0005, 3); push_byte(8'h7F);
        check_bits("abort", 1);
        check("abort tx c20", 32'(tx_log[20]), 32'd1);
        check("abort busy c19", 32'(busy_log[19]), 32'd1);
        check("abort pulse c20", 32'(ab_log[20]), 32'd1);
        check("abort busy c20", 32'(busy_log[20]), 32'd0);
        check("abort ab count", 32'(count(2, 1, 30)), 32'd1);
        check("abort done count", 32'(count(1, 1, 30)), 32'd0);
        check("abort rd total", 32'(count(0, 1, 30)), 32'd2);
        check("abort rd after", 32'(count(0, 12, 30)), 32'd0);

        // Enable dropped during FCS, then requests with enable low
        mem[0] = 8'h00;
        frame(1, 1, 35, -1, -1, 20, -1);
        push_byte(8'h7E); push_byte(8'h00);
        check_bits("endrop head", 1);
        push_byte(8'h7F);
        check_bits("endrop abort", 21);
        check("endrop pulse c29", 32'(ab_log[29]), 32'd1);
        check("endrop busy c29", 32'(busy_log[29]), 32'd0);
        check("endrop done count", 32'(count(1, 1, 35)), 32'd0);
        check("endrop ab count", 32'(count(2, 1, 35)), 32'd1);
        frame(3, 0, 20, -1, -1, 0, -1);
        check("disabled busy", 32'(count(3, 1, 20)), 32'd0);
        check("disabled rd", 32'(count(0, 1, 20)), 32'd0);
        check("disabled tx", 32'(count(4, 1, 20)), 32'd20);

        // Reset during data, then a clean frame
        mem[0] = 8'h55; mem[1] = 8'h55;
        frame(2, 0, 40, -1, -1, -1, 12);
        check("rst busy c12", 32'(busy_log[12]), 32'd1);
        check("rst tx c13", 32'(tx_log[13]), 32'd1);
        check("rst rd c13", 32'(rd_log[13]), 32'd0);
        check("rst busy c13", 32'(busy_log[13]), 32'd0);
        check("rst done c13", 32'(done_log[13]), 32'd0);
        check("rst ab c13", 32'(ab_log[13]), 32'd0);
        check("rst busy after", 32'(count(3, 13, 40)), 32'd0);
        check("rst done count", 32'(count(1, 1, 40)), 32'd0);
        check("rst ab count", 32'(count(2, 1, 40)), 32'd0);
        mem[0] = 8'h0F;
        frame(1, 0, 30, -1, -1, -1, -1);
        push_byte(8'h7E); push_byte(8'h0F); push_byte(8'h7E);
        check_bits("post rst", 1);
        check("post rst done c25", 32'(done_log[25]), 32'd1);
        check("post rst rd count", 32'(count(0, 1, 30)), 32'd1);

        // Oversized frame is clamped to 126 bytes
        for (int a = 0; a < 128; a++) mem[a] = 8'h00;
        frame(127, 0, 1030, -1, -1, -1, -1);
        check("clamp rd count", 32'(count(0, 1, 1030)), 32'd126);
        check("clamp busy c1024", 32'(busy_log[1024]), 32'd1);
        check("clamp done c1025", 32'(done_log[1025]), 32'd1);
        check("clamp tx c1017", 32'(tx_log[1017]), 32'd0);
        check("clamp tx c1018", 32'(tx_log[1018]), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
